sobel_stream_filter: RTL and testbench

- Downstream consumer of the 320x240x8 M10K grayscale frame buffer.
- After `start`, it raster-scans the buffer through the read port at one pixel per clock, forms a 3x3 window from two internal line buffers, computes |Gx|+|Gy|, and streams 8-bit edge pixels into a second M10K frame buffer through its write port.
- `done` pulses for the VGA/HPS controller when the frame is finished.

---
 rtl/sobel_stream_filter_if.sv | 25 ++
 rtl/sobel_stream_filter.sv | 165 ++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_filter_if.sv
// Frame-buffer read/write ports and control handshake of the Sobel stream filter.
// The master side drives start/threshold and the source pixel, and the slave side is the filter.
interface sobel_stream_filter_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic [7:0]        threshold;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;

    modport master (
        output start, threshold, rd_data,
        input  rd_addr, wr_addr, wr_data, wr_en, busy, done
    );

    modport slave (
        input  start, threshold, rd_data,
        output rd_addr, wr_addr, wr_data, wr_en, busy, done
    );
endinterface

// File: rtl/sobel_stream_filter.sv
// Raster-scans a grayscale frame and forms a 3x3 window from two line buffers.
// It writes |Gx|+|Gy| (saturated, or thresholded to binary) to a second frame, three cycles after each read.
module sobel_stream_filter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    sobel_stream_filter_if.slave bus
);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr, r_a1, r_a2, r_wr_addr;
    logic [X_W-1:0]    r_rx, r_x1;
    logic [Y_W-1:0]    r_ry, r_y1;
    logic [7:0]        r_thr, r_wr_data;
    logic              r_v1, r_v2, r_wr_en, r_busy, r_done;
    logic [10:0]       r_mag2;

    logic [7:0] r_lb_prev [WIDTH];   // row yp-1
    logic [7:0] r_lb_old  [WIDTH];   // row yp-2
    logic [7:0] r_win     [3][2];    // [row][col]: columns xp-2 and xp-1 of the last three rows

    logic [7:0]         w_col [3];
    logic signed [10:0] w_gx, w_gy;
    logic [10:0]        w_agx, w_agy, w_mag;
    logic               w_border;
    logic [7:0]         w_result;

    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Column entering the window this cycle: top from the older line buffer, bottom straight from memory.
    always_comb begin
        w_col[0] = r_lb_old[r_x1];
        w_col[1] = r_lb_prev[r_x1];
        w_col[2] = bus.rd_data;
    end

    assign w_gx = $signed({1'b0, wsum(w_col[0], w_col[1], w_col[2])})
                - $signed({1'b0, wsum(r_win[0][0], r_win[1][0], r_win[2][0])});
    assign w_gy = $signed({1'b0, wsum(r_win[2][0], r_win[2][1], w_col[2])})
                - $signed({1'b0, wsum(r_win[0][0], r_win[0][1], w_col[0])});
    assign w_agx    = w_gx[10] ? 11'(-w_gx) : 11'(w_gx);
    assign w_agy    = w_gy[10] ? 11'(-w_gy) : 11'(w_gy);
    assign w_mag    = w_agx + w_agy;
    assign w_border = (r_x1 < X_W'(2)) || (r_y1 < Y_W'(2));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_result = 8'h00;
        if (r_thr == 8'h00) begin
            w_result = (r_mag2 > 11'd255) ? 8'hFF : r_mag2[7:0];
        end else if (r_mag2 >= {3'b000, r_thr}) begin
            w_result = 8'hFF;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_rx      <= '0;
            r_ry      <= '0;
            r_thr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_thr     <= bus.threshold;
                        r_rd_addr <= '0;
                        r_rx      <= '0;
                        r_ry      <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        r_state <= S_FLUSH;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                        if (r_rx == LAST_X) begin
                            r_rx <= '0;
                            r_ry <= r_ry + 1'b1;
                        end else begin
                            r_rx <= r_rx + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Both stages empty means the final write is on the bus this cycle.
                    if (!r_v1 && !r_v2) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_a1      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_v2      <= 1'b0;
            r_a2      <= '0;
            r_mag2    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_v1   <= (r_state == S_SCAN);
            r_a1   <= r_rd_addr;
            r_x1   <= r_rx;
            r_y1   <= r_ry;
            r_v2   <= r_v1;
            r_a2   <= r_a1;
            r_mag2 <= w_border ? 11'd0 : w_mag;
            r_wr_en <= r_v2;
            if (r_v2) begin
                r_wr_addr <= r_a2;
                r_wr_data <= w_result;
            end
        end
    end

    // NOTE: line buffers and window registers carry no reset; the border rule masks stale contents.
    always_ff @(posedge clk) begin
        if (r_v1) begin
            r_lb_old[r_x1]  <= r_lb_prev[r_x1];
            r_lb_prev[r_x1] <= bus.rd_data;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col[r];
            end
        end
    end

    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_en   = r_wr_en;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on a reduced 16x6 frame with directed image patterns.
// Expected pixels are pushed per frame and a negedge monitor pops them on each write.
module tb_sobel_stream_filter;
    localparam int W  = 16;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 17;

    typedef enum int {P_FLAT100, P_FLAT50, P_VSTEP, P_RAMP, P_XYRAMP, P_HFALL, P_VFALL} pat_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic  clk;
    logic  reset;
    pat_t  pat;
    exp_t  sb[$];
    exp_t  e;
    logic [AW-1:0] rd_hist [3];
    int    n_vec = 0;
    int    n_err = 0;

    sobel_stream_filter_if #(.ADDR_W(AW)) bus ();

    sobel_stream_filter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input pat_t p, input int x, input int y);
        case (p)
            P_FLAT100: return 8'd100;
            P_FLAT50:  return 8'd50;
            P_VSTEP:   return (x < 8) ? 8'd0 : 8'd200;
            P_RAMP:    return 8'(x);
            P_XYRAMP:  return 8'(x + 2 * y);
            P_HFALL:   return (y < 3) ? 8'd50 : 8'd0;
            P_VFALL:   return (x < 8) ? 8'd30 : 8'd0;
            default:   return 8'd0;
        endcase
    endfunction

    // Hand-derived |Gx|+|Gy| for each pattern at window position (x, y).
    function automatic logic [7:0] exp_pix(input pat_t p, input int thr, input int x, input int y);
        int mag;
        if (x < 2 || y < 2) return 8'd0;
        case (p)
            P_VSTEP:  mag = (x == 8 || x == 9) ? 800 : 0;
            P_RAMP:   mag = 8;
            P_XYRAMP: mag = 24;
            P_HFALL:  mag = (y == 3 || y == 4) ? 200 : 0;
            P_VFALL:  mag = (x == 8 || x == 9) ? 120 : 0;
            default:  mag = 0;
        endcase
        if (thr == 0) return (mag > 255) ? 8'd255 : 8'(mag);
        return (mag >= thr) ? 8'd255 : 8'd0;
    endfunction

    // Source frame buffer: one cycle read latency.
    always @(posedge clk) begin
        bus.rd_data <= pix(pat, int'(bus.rd_addr) % W, int'(bus.rd_addr) / W);
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            check("wr_addr_vs_rd_addr_3_back", 32'(bus.wr_addr), 32'(rd_hist[2]));
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_write: addr %0d data %0d with no expected entry", bus.wr_addr, bus.wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
        rd_hist[2] = rd_hist[1];
        rd_hist[1] = rd_hist[0];
        rd_hist[0] = bus.rd_addr;
    end

    task automatic push_frame(input pat_t p, input int thr);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sb.push_back('{addr: AW'(y * W + x), data: exp_pix(p, thr, x, y)});
    endtask

    task automatic run_frame(input pat_t p, input logic [7:0] thr, input int mid_start);
        int first_wr, last_wr, n_wr, n_done, done_c, n_busy;
        pat = p;
        push_frame(p, int'(thr));
        @(negedge clk);
        bus.start     = 1'b1;
        bus.threshold = thr;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.threshold = 8'hAA;
        check("first_rd_addr", 32'(bus.rd_addr), 32'd0);
        first_wr = -1; last_wr = -1; n_wr = 0; n_done = 0; done_c = -1; n_busy = 0;
        for (int c = 0; c < N + 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == mid_start)          bus.start = 1'b1;
            else if (c == mid_start + 1) bus.start = 1'b0;
            if (bus.busy) n_busy++;
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                n_wr++;
            end
            if (bus.done) begin
                n_done++;
                done_c = c;
            end
        end
        check("first_write_latency", 32'(first_wr), 32'd3);
        check("write_count", 32'(n_wr), 32'(N));
        check("writes_without_gap", 32'(last_wr - first_wr + 1), 32'(N));
        check("done_pulses", 32'(n_done), 32'd1);
        check("done_after_last_write", 32'(done_c), 32'(last_wr + 1));
        check("busy_cycles", 32'(n_busy), 32'(N + 3));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic abort_test();
        bit reached;
        int n_done;
        pat = P_VSTEP;
        push_frame(P_VSTEP, 0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.threshold = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 4 * N; c++) begin
            if (bus.rd_addr == AW'(40)) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_pixel_40", 32'(reached), 32'd1);
        check("abort_wr_en_before_reset", 32'(bus.wr_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_wr_en_async", 32'(bus.wr_en), 32'd0);
        check("abort_busy_async", 32'(bus.busy), 32'd0);
        check("abort_rd_addr_async", 32'(bus.rd_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        reset = 1'b0;
        n_done = 0;
        repeat (2 * N) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_stays_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.threshold = 8'd0;
        pat           = P_FLAT100;
        repeat (3) @(negedge clk);
        check("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset_wr_data", 32'(bus.wr_data), 32'd0);
        check("reset_wr_en",   32'(bus.wr_en),   32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_done",    32'(bus.done),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(P_FLAT100, 8'd0,   -1);
        run_frame(P_VSTEP,   8'd0,   -1);
        run_frame(P_RAMP,    8'd0,   -1);
        run_frame(P_RAMP,    8'd8,   -1);
        run_frame(P_RAMP,    8'd9,   -1);
        run_frame(P_XYRAMP,  8'd0,   -1);
        run_frame(P_HFALL,   8'd0,   -1);
        run_frame(P_VFALL,   8'd120, -1);
        run_frame(P_RAMP,    8'd0,   40);
        abort_test();
        run_frame(P_FLAT50,  8'd0,   -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
